button_event_decoder: RTL and testbench

Classifies the debounced push-button level from `debounce_ckt` (its `result` output) into discrete user events: single press, double press and long press. Sits directly downstream of the debouncer and upstream of the application control logic. Every event is a one-cycle registered pulse, so consumers need no edge detection of their own.

---
 rtl/btn_evt_pkg.sv | 25 ++
 rtl/button_event_decoder.sv | 142 ++++++++++++++
 tb/tb_button_event_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared definitions for the push-button event decoder: FSM state
// encoding, default timing constants at the board clock and the event
// counter width.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } btn_state_t;

  // One second of hold at the 50 MHz board clock counts as a long press.
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  // A quarter second after release is allowed for the second click.
  localparam int DEF_DCLICK_CYCLES = 12_500_000;

  localparam int EVT_CNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns the debounced button level into single, double and long press
// events, each a one-cycle registered pulse. busy flags an in-progress
// sequence. Optional event counter enabled by defining BTN_EVT_COUNT_EN;
// without it evt_count is tied to zero.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn,
  output logic                 single_press,
  output logic                 double_press,
  output logic                 long_press,
  output logic                 busy,
  output logic [EVT_CNT_W-1:0] evt_count
);

  // Timer width is derived from the longer of the two intervals so both
  // terminal counts fit; it is not meant to be overridden.
  localparam int TMR_W = $clog2(max_int(LONG_CYCLES, DCLICK_CYCLES)) + 1;

  localparam logic [TMR_W-1:0] LONG_LAST   = TMR_W'(LONG_CYCLES - 1);
  localparam logic [TMR_W-1:0] DCLICK_LAST = TMR_W'(DCLICK_CYCLES - 1);

  btn_state_t       state;
  logic [TMR_W-1:0] timer;
  logic             btn_q;

  // Single FSM: registers the button once, runs the state timer and
  // produces all event pulses and busy as registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      btn_q        <= 1'b0;
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn;
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      timer        <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (btn_q) begin
            state <= PRESS1;
            timer <= '0;
            busy  <= 1'b1;
          end
        end

        PRESS1: begin
          if (!btn_q) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state      <= HOLD;
            timer      <= '0;
            long_press <= 1'b1;
          end
        end

        WAIT2: begin
          if (btn_q) begin
            state <= PRESS2;
            timer <= '0;
          end else if (timer == DCLICK_LAST) begin
            state        <= IDLE;
            timer        <= '0;
            single_press <= 1'b1;
            busy         <= 1'b0;
          end
        end

        PRESS2: begin
          if (!btn_q) begin
            state        <= IDLE;
            timer        <= '0;
            double_press <= 1'b1;
            busy         <= 1'b0;
          end else if (timer == LONG_LAST) begin
            state      <= HOLD;
            timer      <= '0;
            long_press <= 1'b1;
          end
        end

        HOLD: begin
          if (!btn_q) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTN_EVT_COUNT_EN
  logic                 evt_fire;
  logic [EVT_CNT_W-1:0] evt_cnt;

  // Flags the edge on which the FSM is about to emit any event, so the
  // count changes in the same cycle the pulse becomes visible.
  always_comb begin
    evt_fire = 1'b0;
    case (state)
      PRESS1:  evt_fire = btn_q && (timer == LONG_LAST);
      WAIT2:   evt_fire = !btn_q && (timer == DCLICK_LAST);
      PRESS2:  evt_fire = !btn_q || (timer == LONG_LAST);
      default: evt_fire = 1'b0;
    endcase
  end

  // Free-running event counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (evt_fire) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

  assign evt_count = evt_cnt;
`else
  assign evt_count = '0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8 and
// DCLICK_CYCLES=4. Expected evt_count follows BTN_EVT_COUNT_EN: the
// running event count modulo 256 when defined, zero otherwise.
module tb_button_event_decoder;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       single_press;
  logic       double_press;
  logic       long_press;
  logic       busy;
  logic [7:0] evt_count;

  int vecCount  = 0;
  int missCount = 0;

  // Per-sequence observations, edge 0 being the first driven cycle.
  int edgeIdx;
  int spCnt, dpCnt, lpCnt;
  int spEdge, dpEdge, lpEdge;
  int busyRise, busyFall;
  int multiCnt = 0;

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .DCLICK_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .single_press(single_press),
    .double_press(double_press),
    .long_press  (long_press),
    .busy        (busy),
    .evt_count   (evt_count)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expEvt(input int n);
`ifdef BTN_EVT_COUNT_EN
    return n % 256;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic startSeq();
    edgeIdx  = 0;
    spCnt    = 0; dpCnt  = 0; lpCnt  = 0;
    spEdge   = -1; dpEdge = -1; lpEdge = -1;
    busyRise = -1; busyFall = -1;
  endtask

  // Drives btn at level for n cycles, sampling outputs 1 ns after each edge.
  task automatic applyStimulus(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      btn = level;
      @(posedge clk);
      #1;
      if (single_press) begin spCnt++; spEdge = edgeIdx; end
      if (double_press) begin dpCnt++; dpEdge = edgeIdx; end
      if (long_press)   begin lpCnt++; lpEdge = edgeIdx; end
      if ((32'(single_press) + 32'(double_press) + 32'(long_press)) > 1) multiCnt++;
      if (busy && busyRise < 0) busyRise = edgeIdx;
      if (!busy && busyRise >= 0 && busyFall < 0) busyFall = edgeIdx;
      edgeIdx++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    btn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_single", 32'(single_press), 0);
    checkOutput("rst_double", 32'(double_press), 0);
    checkOutput("rst_long",   32'(long_press),   0);
    checkOutput("rst_busy",   32'(busy),         0);
    checkOutput("rst_evt",    32'(evt_count),    0);

    $display("[TB] short press");
    startSeq();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    checkOutput("short_sp_cnt",  spCnt, 1);
    checkOutput("short_sp_edge", spEdge, 8);
    checkOutput("short_dp_cnt",  dpCnt, 0);
    checkOutput("short_lp_cnt",  lpCnt, 0);
    checkOutput("short_busy_rise", busyRise, 1);
    checkOutput("short_busy_fall", busyFall, 8);
    checkOutput("short_evt", 32'(evt_count), expEvt(1));

    $display("[TB] double press");
    doReset();
    startSeq();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 8);
    checkOutput("double_dp_cnt",  dpCnt, 1);
    checkOutput("double_dp_edge", dpEdge, 9);
    checkOutput("double_sp_cnt",  spCnt, 0);
    checkOutput("double_lp_cnt",  lpCnt, 0);
    checkOutput("double_busy_fall", busyFall, 9);
    checkOutput("double_evt", 32'(evt_count), expEvt(1));

    $display("[TB] long press");
    doReset();
    startSeq();
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 8);
    checkOutput("long_lp_cnt",  lpCnt, 1);
    checkOutput("long_lp_edge", lpEdge, 9);
    checkOutput("long_sp_cnt",  spCnt, 0);
    checkOutput("long_dp_cnt",  dpCnt, 0);
    checkOutput("long_busy_fall", busyFall, 21);
    checkOutput("long_evt", 32'(evt_count), expEvt(1));

    $display("[TB] hold of 8 samples");
    doReset();
    startSeq();
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 10);
    checkOutput("h8_sp_cnt",  spCnt, 1);
    checkOutput("h8_sp_edge", spEdge, 13);
    checkOutput("h8_lp_cnt",  lpCnt, 0);

    $display("[TB] hold of 9 samples");
    doReset();
    startSeq();
    applyStimulus(1'b1, 9);
    applyStimulus(1'b0, 8);
    checkOutput("h9_lp_cnt",  lpCnt, 1);
    checkOutput("h9_lp_edge", lpEdge, 9);
    checkOutput("h9_sp_cnt",  spCnt, 0);
    checkOutput("h9_busy_fall", busyFall, 10);

    $display("[TB] re-press on WAIT2 timeout cycle");
    doReset();
    startSeq();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 8);
    checkOutput("edge_dp_cnt",  dpCnt, 1);
    checkOutput("edge_dp_edge", dpEdge, 11);
    checkOutput("edge_sp_cnt",  spCnt, 0);

    $display("[TB] reset during WAIT2");
    doReset();
    startSeq();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 2);
    checkOutput("mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_busy",  32'(busy), 0);
    checkOutput("mid_evt",   32'(evt_count), 0);
    checkOutput("mid_pulse", 32'(single_press | double_press | long_press), 0);
    startSeq();
    applyStimulus(1'b0, 10);
    checkOutput("mid_after_pulses", spCnt + dpCnt + lpCnt, 0);

    $display("[TB] event counter wrap");
    doReset();
    startSeq();
    for (int p = 0; p < 255; p++) begin
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 7);
    end
    checkOutput("wrap_sp_255", spCnt, 255);
    checkOutput("wrap_evt_255", 32'(evt_count), expEvt(255));
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 7);
    checkOutput("wrap_sp_256", spCnt, 256);
    checkOutput("wrap_evt_256", 32'(evt_count), expEvt(256));
    checkOutput("wrap_other", dpCnt + lpCnt, 0);

    checkOutput("one_hot_pulses", multiCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
